muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the EX stage. It accepts one operation at a time and runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, then applies sign correction. While an operation is in flight it stalls the pipeline. It returns one registered 32-bit result with a one-cycle valid pulse.

---
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the EX stage.
// One operation at a time: 32 iterations of shift-add multiply or restoring
// divide on operand magnitudes, then a sign-fix cycle, then a one-cycle
// valid pulse with the registered result.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   EX holds an M-extension op this cycle
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   src_a   in   rs1 operand
//   src_b   in   rs2 operand
//   flush   in   kill the in-flight or starting op
//   stall   out  freeze IF/ID/EX (combinational)
//   valid   out  result valid, one-cycle pulse (registered)
//   result  out  registered result
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_next;
  logic [4:0]          cnt;
  logic [2:0]          op;
  logic                sgn_a, sgn_b;
  logic [XLEN-1:0]     opnd;      // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0]   acc;       // product hi:lo (mul) or remainder:dividend (div)

  logic                accept;
  logic                a_signed, b_signed, in_sgn_a, in_sgn_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                b_zero, ovf, special;
  logic [XLEN-1:0]     special_val;
  logic [XLEN:0]       mul_sum, rem_sh, trial;
  logic [2*XLEN-1:0]   acc_step, prod;
  logic [XLEN-1:0]     quot, rem, fix_val;

  // Operand capture, special cases and the per-iteration datapath.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sgn_a = a_signed && src_a[XLEN-1];
    in_sgn_b = b_signed && src_b[XLEN-1];
    mag_a    = in_sgn_a ? -src_a : src_a;
    mag_b    = in_sgn_b ? -src_b : src_b;

    b_zero  = (src_b == '0);
    ovf     = (src_a == MIN_NEG) && (src_b == '1) && !funct3[0];
    special = funct3[2] && (b_zero || ovf);
    if (b_zero) special_val = funct3[1] ? src_a : '1;
    else        special_val = funct3[1] ? '0 : MIN_NEG;

    // Multiply: add multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole thing right.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shifted partial remainder, trial-subtract the divisor.
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    trial   = rem_sh - {1'b0, opnd};

    if (!op[2])          acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (!trial[XLEN]) acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                 acc_step = {acc[2*XLEN-2:0], 1'b0};

    prod = (sgn_a ^ sgn_b) ? -acc : acc;
    quot = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (op[2]) begin
      if (op[1]) fix_val = sgn_a ? -rem : rem;
      else       fix_val = (sgn_a ^ sgn_b) ? -quot : quot;
    end else begin
      fix_val = (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        accept     = 1'b1;
        stall      = 1'b1;
        state_next = special ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (cnt == 5'd0) state_next = FIX;
      end
      FIX: begin
        stall      = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      op     <= 3'b000;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= (state_next == DONE);
      if (flush) begin
        cnt <= 5'd0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            op    <= funct3;
            sgn_a <= in_sgn_a;
            sgn_b <= in_sgn_b;
            cnt   <= 5'd31;
            opnd  <= funct3[2] ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            if (special) result <= special_val;
          end
          CALC: begin
            acc <= acc_step;
            cnt <= cnt - 5'd1;
          end
          FIX:     result <= fix_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            stall, valid;
  logic [XLEN-1:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] last_exp = '0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = 0;
    u  = '0;
    case (f)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
      3'd4: begin if (b == 0) return '1; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one op at a negedge (cycle 0) and follow it to its valid pulse.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit noise);
    int unsigned lat, want;
    bit busy_ok;
    want    = is_special(f, a, b) ? 1 : 34;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    #1;
    check("stall_c0", {31'd0, stall}, 32'd1);
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      start = noise;
      if (noise) begin
        funct3 = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
      end
      #1;
      if (valid) break;
      if (!stall) busy_ok = 1'b0;
    end
    start = 1'b0;
    check("latency", lat, want);
    check("busy_stall", {31'd0, busy_ok}, 32'd1);
    check("done_stall", {31'd0, stall}, 32'd0);
    check("result", result, exp);
    last_exp = exp;
    @(negedge clk);
    #1;
    check("valid_pulse", {31'd0, valid}, 32'd0);
    check("result_hold", result, exp);
  endtask

  task automatic expect_no_valid(input string tag, input int unsigned cycles);
    int unsigned nv;
    nv = 0;
    repeat (cycles) begin
      @(negedge clk);
      #1;
      if (valid) nv++;
    end
    check(tag, nv, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    #1;
    check("rst_result", result, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Special cases: one-cycle latency.
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    // Full iterations.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);

    // Flush mid-divide: back to IDLE next cycle, no pulse, result untouched.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_c10_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_c11_stall", {31'd0, stall}, 32'd0);
    check("flush_c11_valid", {31'd0, valid}, 32'd0);
    expect_no_valid("flush_novalid", 40);
    check("flush_result", result, last_exp);

    // start together with flush in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd5;
    #1;
    check("sf_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("sf_stall_next", {31'd0, stall}, 32'd0);
    expect_no_valid("sf_novalid", 40);

    // Reset mid-multiply.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; src_a = 32'd12345; src_b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_valid("midrst_novalid", 40);
    run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b0);

    // Randomized ops against the reference model.
    repeat (60) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, model(f, a, b), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
